// File: rtl/nav_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nav_pkg
// Purpose  : Shared types and constants for the navigation command sequencer.
//            Holds the sequencer state encoding and the command opcodes.
// Contents : nav_state_t          - sequencer state enum
//            OPC_HDNG / OPC_MOVE  - command opcodes (cmd[15:13])
// Revision : 1.0 - initial release
// ============================================================================
package nav_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDNG    = 2'd1,
    ST_RAMP_UP = 2'd2,
    ST_RAMP_DN = 2'd3
  } nav_state_t;

  localparam logic [2:0] OPC_HDNG = 3'b001;
  localparam logic [2:0] OPC_MOVE = 3'b010;

endpackage
`default_nettype wire

// File: rtl/nav_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : nav_seq_if
// Purpose  : Command handshake between the command processor (master) and
//            the navigation sequencer (slave).
// Signals  : cmd[15:0]    - command word (opcode in [15:13])
//            cmd_rdy      - a command is pending
//            clr_cmd_rdy  - one-cycle acknowledge that cmd was consumed
// Revision : 1.0 - initial release
// ============================================================================
interface nav_seq_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;

  modport master (output cmd, output cmd_rdy, input  clr_cmd_rdy);
  modport slave  (input  cmd, input  cmd_rdy, output clr_cmd_rdy);
endinterface
`default_nettype wire

// File: rtl/nav_seq_spd_ramp.sv
`default_nettype none
// ============================================================================
// Module   : spd_ramp
// Purpose  : Forward-speed register with saturating ramp. On each enabled
//            cycle the speed either steps up by SPD_INC (clamped to MAX_SPD)
//            or down by i_decel (clamped at zero); otherwise it holds.
// Ports    : clk, rst_n    - clock, asynchronous active-low reset
//            i_en          - step enable (heading-valid strobe)
//            i_up / i_dn   - step direction select (mutually exclusive)
//            i_decel[12:0] - deceleration step
//            o_spd[10:0]   - registered speed
//            o_spd_nxt     - value the register loads on this edge
// Revision : 1.0 - initial release
// ============================================================================
module spd_ramp #(
  parameter logic [10:0] SPD_INC = 11'h018,
  parameter logic [10:0] MAX_SPD = 11'h2A0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_en,
  input  wire logic        i_up,
  input  wire logic        i_dn,
  input  wire logic [12:0] i_decel,
  output logic      [10:0] o_spd,
  output logic      [10:0] o_spd_nxt
);

  logic [10:0] r_spd;
  logic [11:0] w_sum;
  logic [10:0] w_up;
  logic [12:0] w_diff;
  logic [10:0] w_dn;

  // Add is one bit wider so the MAX_SPD clamp sees the true sum.
  assign w_sum  = {1'b0, r_spd} + {1'b0, SPD_INC};
  assign w_up   = (w_sum > {1'b0, MAX_SPD}) ? MAX_SPD : w_sum[10:0];

  // Subtract in 13 bits; a decel larger than the speed floors at zero.
  assign w_diff = {2'b00, r_spd} - i_decel;
  assign w_dn   = (i_decel > {2'b00, r_spd}) ? 11'd0 : w_diff[10:0];

  always_comb begin
    o_spd_nxt = r_spd;
    if (i_en && i_up)      o_spd_nxt = w_up;
    else if (i_en && i_dn) o_spd_nxt = w_dn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_spd <= 11'd0;
    else        r_spd <= o_spd_nxt;
  end

  assign o_spd = r_spd;

endmodule
`default_nettype wire

// File: rtl/nav_seq.sv
`default_nettype none
// ============================================================================
// Module   : nav_seq
// Purpose  : Motion command sequencer feeding the heading PID. Accepts one
//            heading or move command at a time, ramps forward speed on
//            heading-valid strobes, stops on wall openings or obstructions
//            and pulses o_mv_cmplt when each command finishes.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            cmd_if (slave)  - cmd / cmd_rdy / clr_cmd_rdy handshake
//            i_hdng_vld      - heading sample strobe
//            i_at_hdng       - heading error within tolerance
//            i_frwrd_opn     - path ahead clear (0 = emergency stop)
//            i_lft_opn/i_rght_opn - side openings (rising edge = stop point)
//            o_moving        - PID enable
//            o_dsrd_hdng     - desired heading (signed 12 bit)
//            o_frwrd_spd     - forward speed (unsigned 11 bit)
//            o_mv_cmplt      - one-cycle command-complete pulse
//            o_tmo_err       - sticky heading timeout flag
// Options  : NAV_TIMEOUT_EN  - enables the HDNG settle timeout (TMO_CYC);
//                              without it o_tmo_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module nav_seq
  import nav_pkg::*;
#(
  parameter logic [10:0] SPD_INC = 11'h018,
  parameter logic [10:0] MAX_SPD = 11'h2A0,
  parameter logic [23:0] TMO_CYC = 24'hFF_FFFF
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  nav_seq_if.slave         cmd_if,
  input  wire logic        i_hdng_vld,
  input  wire logic        i_at_hdng,
  input  wire logic        i_frwrd_opn,
  input  wire logic        i_lft_opn,
  input  wire logic        i_rght_opn,
  output logic             o_moving,
  output logic signed [11:0] o_dsrd_hdng,
  output logic      [10:0] o_frwrd_spd,
  output logic             o_mv_cmplt,
  output logic             o_tmo_err
);

  localparam logic [12:0] c_DEC_NRM = {1'b0, SPD_INC, 1'b0};
  localparam logic [12:0] c_DEC_EMG = {SPD_INC, 2'b00};

  nav_state_t   r_state;
  logic         r_moving;
  logic [11:0]  r_dsrd_hdng;
  logic         r_clr_cmd_rdy;
  logic         r_mv_cmplt;
  logic         r_stp_lft;
  logic         r_stp_rght;
  logic [12:0]  r_decel;
  logic         r_lft_q;
  logic         r_rght_q;

  logic [2:0]   w_opc;
  logic         w_lft_rise;
  logic         w_rght_rise;
  logic         w_nrm_stop;
  logic [12:0]  w_decel;
  logic [10:0]  w_spd;
  logic [10:0]  w_spd_nxt;
  logic         w_unused_cmd;

  assign w_opc        = cmd_if.cmd[15:13];
  assign w_unused_cmd = cmd_if.cmd[12];

  assign w_lft_rise  = i_lft_opn  & ~r_lft_q;
  assign w_rght_rise = i_rght_opn & ~r_rght_q;
  assign w_nrm_stop  = (w_lft_rise & r_stp_lft) | (w_rght_rise & r_stp_rght);

  // An obstruction during deceleration takes effect on the very next strobe.
  assign w_decel = ((r_state == ST_RAMP_DN) && !i_frwrd_opn) ? c_DEC_EMG : r_decel;

  spd_ramp #(
    .SPD_INC (SPD_INC),
    .MAX_SPD (MAX_SPD)
  ) u_spd_ramp (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (i_hdng_vld),
    .i_up      (r_state == ST_RAMP_UP),
    .i_dn      (r_state == ST_RAMP_DN),
    .i_decel   (w_decel),
    .o_spd     (w_spd),
    .o_spd_nxt (w_spd_nxt)
  );

`ifdef NAV_TIMEOUT_EN
  localparam logic [23:0] c_TMO_LAST = TMO_CYC - 24'd1;
  logic [23:0] r_tmo_cnt;
  logic        r_tmo_err;
`else
  logic        w_unused_tmo;
  assign w_unused_tmo = |TMO_CYC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_moving      <= 1'b0;
      r_dsrd_hdng   <= 12'h000;
      r_clr_cmd_rdy <= 1'b0;
      r_mv_cmplt    <= 1'b0;
      r_stp_lft     <= 1'b0;
      r_stp_rght    <= 1'b0;
      r_decel       <= c_DEC_NRM;
      r_lft_q       <= 1'b0;
      r_rght_q      <= 1'b0;
`ifdef NAV_TIMEOUT_EN
      r_tmo_cnt     <= 24'd0;
      r_tmo_err     <= 1'b0;
`endif
    end else begin
      r_lft_q       <= i_lft_opn;
      r_rght_q      <= i_rght_opn;
      r_clr_cmd_rdy <= 1'b0;
      r_mv_cmplt    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The processor drops cmd_rdy only after seeing the acknowledge,
          // so skip the cycle in which the acknowledge is still high.
          if (cmd_if.cmd_rdy && !r_clr_cmd_rdy) begin
            r_clr_cmd_rdy <= 1'b1;
            if (w_opc == OPC_HDNG) begin
              r_dsrd_hdng <= cmd_if.cmd[11:0];
              r_moving    <= 1'b1;
              r_state     <= ST_HDNG;
`ifdef NAV_TIMEOUT_EN
              r_tmo_cnt   <= 24'd0;
              r_tmo_err   <= 1'b0;
`endif
            end else if (w_opc == OPC_MOVE) begin
              r_stp_lft   <= cmd_if.cmd[1];
              r_stp_rght  <= cmd_if.cmd[0];
              r_decel     <= c_DEC_NRM;
              r_moving    <= 1'b1;
              r_state     <= ST_RAMP_UP;
`ifdef NAV_TIMEOUT_EN
              r_tmo_err   <= 1'b0;
`endif
            end
          end
        end
        ST_HDNG: begin
          if (i_hdng_vld && i_at_hdng) begin
            r_mv_cmplt <= 1'b1;
            r_moving   <= 1'b0;
            r_state    <= ST_IDLE;
          end
`ifdef NAV_TIMEOUT_EN
          else if (r_tmo_cnt == c_TMO_LAST) begin
            r_tmo_err  <= 1'b1;
            r_mv_cmplt <= 1'b1;
            r_moving   <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_tmo_cnt  <= r_tmo_cnt + 24'd1;
          end
`endif
        end
        ST_RAMP_UP: begin
          // Emergency wins over a simultaneous opening edge.
          if (!i_frwrd_opn) begin
            r_decel <= c_DEC_EMG;
            r_state <= ST_RAMP_DN;
          end else if (w_nrm_stop) begin
            r_decel <= c_DEC_NRM;
            r_state <= ST_RAMP_DN;
          end
        end
        ST_RAMP_DN: begin
          if (!i_frwrd_opn) r_decel <= c_DEC_EMG;
          if (i_hdng_vld && (w_spd_nxt == 11'd0)) begin
            r_mv_cmplt <= 1'b1;
            r_moving   <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_moving <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_if.clr_cmd_rdy = r_clr_cmd_rdy;
  assign o_moving           = r_moving;
  assign o_dsrd_hdng        = r_dsrd_hdng;
  assign o_frwrd_spd        = w_spd;
  assign o_mv_cmplt         = r_mv_cmplt;
`ifdef NAV_TIMEOUT_EN
  assign o_tmo_err          = r_tmo_err;
`else
  assign o_tmo_err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nav_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nav_seq
// Purpose  : Self-checking bench for nav_seq. Directed steps drive commands
//            and heading strobes; a speed model pushes expected results to a
//            queue that is popped and compared after each strobe.
// Options  : NAV_TIMEOUT_EN - also runs the heading-timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nav_seq;

  typedef struct packed {
    logic [10:0] spd;
    logic        cmplt;
    logic        moving;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_hdng_vld;
  logic        i_at_hdng;
  logic        i_frwrd_opn;
  logic        i_lft_opn;
  logic        i_rght_opn;
  logic        o_moving;
  logic [11:0] o_dsrd_hdng;
  logic [10:0] o_frwrd_spd;
  logic        o_mv_cmplt;
  logic        o_tmo_err;

  int   n_pass;
  int   n_tot;
  int   exp_spd;
  exp_t sb_q[$];

  nav_seq_if u_if ();

  nav_seq #(
    .SPD_INC (11'h018),
    .MAX_SPD (11'h2A0),
    .TMO_CYC (24'd100)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_if      (u_if),
    .i_hdng_vld  (i_hdng_vld),
    .i_at_hdng   (i_at_hdng),
    .i_frwrd_opn (i_frwrd_opn),
    .i_lft_opn   (i_lft_opn),
    .i_rght_opn  (i_rght_opn),
    .o_moving    (o_moving),
    .o_dsrd_hdng (o_dsrd_hdng),
    .o_frwrd_spd (o_frwrd_spd),
    .o_mv_cmplt  (o_mv_cmplt),
    .o_tmo_err   (o_tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // One heading-valid strobe; up=1 accelerates, otherwise decelerates by dec.
  task automatic strobe(input bit up, input int dec);
    exp_t e;
    if (up) exp_spd = (exp_spd + 24 > 672) ? 672 : exp_spd + 24;
    else    exp_spd = (exp_spd < dec) ? 0 : exp_spd - dec;
    e.spd    = 11'(exp_spd);
    e.cmplt  = !up && (exp_spd == 0);
    e.moving = !e.cmplt;
    sb_q.push_back(e);
    i_hdng_vld = 1'b1;
    tick();
    i_hdng_vld = 1'b0;
    e = sb_q.pop_front();
    chk("strobe_spd",    24'(o_frwrd_spd), 24'(e.spd));
    chk("strobe_cmplt",  24'(o_mv_cmplt),  24'(e.cmplt));
    chk("strobe_moving", 24'(o_moving),    24'(e.moving));
  endtask

  task automatic send_cmd(input logic [15:0] c);
    u_if.cmd     = c;
    u_if.cmd_rdy = 1'b1;
    tick();
    u_if.cmd_rdy = 1'b0;
    chk("clr_cmd_rdy", 24'(u_if.clr_cmd_rdy), 24'd1);
  endtask

  initial begin
    n_pass = 0; n_tot = 0; exp_spd = 0;
    rst_n = 1'b0;
    u_if.cmd = 16'h0000; u_if.cmd_rdy = 1'b0;
    i_hdng_vld = 1'b0; i_at_hdng = 1'b0; i_frwrd_opn = 1'b1;
    i_lft_opn = 1'b0; i_rght_opn = 1'b0;
    tick(); tick();
    chk("rst_moving", 24'(o_moving),          24'd0);
    chk("rst_hdng",   24'(o_dsrd_hdng),       24'h000);
    chk("rst_spd",    24'(o_frwrd_spd),       24'd0);
    chk("rst_clr",    24'(u_if.clr_cmd_rdy),  24'd0);
    chk("rst_cmplt",  24'(o_mv_cmplt),        24'd0);
    chk("rst_tmo",    24'(o_tmo_err),         24'd0);
    rst_n = 1'b1;
    tick();

    // Heading command
    send_cmd(16'h23FF);
    chk("hdng_val",    24'(o_dsrd_hdng), 24'h3FF);
    chk("hdng_moving", 24'(o_moving),    24'd1);
    chk("hdng_spd",    24'(o_frwrd_spd), 24'd0);
    u_if.cmd = 16'h2123; u_if.cmd_rdy = 1'b1;   // ignored outside IDLE
    tick();
    u_if.cmd_rdy = 1'b0;
    chk("hdng_noack",  24'(u_if.clr_cmd_rdy), 24'd0);
    chk("hdng_keep",   24'(o_dsrd_hdng),      24'h3FF);
    i_hdng_vld = 1'b1; tick(); i_hdng_vld = 1'b0;
    chk("hdng_wait",   24'(o_moving), 24'd1);
    i_at_hdng = 1'b1; i_hdng_vld = 1'b1; tick(); i_hdng_vld = 1'b0; i_at_hdng = 1'b0;
    chk("hdng_cmplt",  24'(o_mv_cmplt), 24'd1);
    chk("hdng_stop",   24'(o_moving),   24'd0);
    tick();
    chk("hdng_pulse1", 24'(o_mv_cmplt), 24'd0);

    // Unknown opcode: acknowledged and discarded
    send_cmd(16'h6000);
    chk("bad_moving", 24'(o_moving), 24'd0);
    tick(); tick();
    chk("bad_cmplt",  24'(o_mv_cmplt), 24'd0);
    chk("bad_idle",   24'(o_moving),   24'd0);

    // Move with stop-on-left; ramp to the ceiling
    send_cmd(16'h4002);
    chk("mv_moving", 24'(o_moving),    24'd1);
    chk("mv_hdng",   24'(o_dsrd_hdng), 24'h3FF);
    exp_spd = 0;
    for (int i = 0; i < 40; i++) begin
      strobe(1'b1, 0);
      if (i == 3) begin
        tick();
        chk("spd_hold", 24'(o_frwrd_spd), 24'(exp_spd));
      end
    end
    chk("spd_max", 24'(o_frwrd_spd), 24'h2A0);
    i_rght_opn = 1'b1; tick();          // not armed: no effect
    strobe(1'b1, 0);
    i_lft_opn = 1'b1; tick();
    for (int i = 0; i < 14; i++) strobe(1'b0, 48);
    tick();
    chk("nrm_pulse1", 24'(o_mv_cmplt), 24'd0);
    i_lft_opn = 1'b0; i_rght_opn = 1'b0;
    tick();

    // Emergency coincident with an opening edge; last step clamps to zero
    send_cmd(16'h4002);
    exp_spd = 0;
    for (int i = 0; i < 10; i++) strobe(1'b1, 0);
    i_frwrd_opn = 1'b0; i_lft_opn = 1'b1; tick();
    i_frwrd_opn = 1'b1;
    for (int i = 0; i < 3; i++) strobe(1'b0, 96);
    i_lft_opn = 1'b0;
    tick();

    // Reset mid-ramp
    send_cmd(16'h4001);
    exp_spd = 0;
    for (int i = 0; i < 5; i++) strobe(1'b1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_spd",    24'(o_frwrd_spd), 24'd0);
    chk("arst_moving", 24'(o_moving),    24'd0);
    chk("arst_hdng",   24'(o_dsrd_hdng), 24'h000);
    chk("arst_cmplt",  24'(o_mv_cmplt),  24'd0);
    tick(); tick();
    chk("arst_nocmpl", 24'(o_mv_cmplt),  24'd0);
    rst_n = 1'b1;
    tick();

`ifdef NAV_TIMEOUT_EN
    send_cmd(16'h2010);
    for (int i = 0; i < 99; i++) tick();
    chk("tmo_early", 24'(o_mv_cmplt), 24'd0);
    tick();
    chk("tmo_err",   24'(o_tmo_err),  24'd1);
    chk("tmo_cmplt", 24'(o_mv_cmplt), 24'd1);
    tick();
    send_cmd(16'h4000);
    chk("tmo_clear", 24'(o_tmo_err),  24'd0);
    i_frwrd_opn = 1'b0; tick(); i_frwrd_opn = 1'b1;
    exp_spd = 0;
    strobe(1'b0, 96);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nav_seq.md
# nav_seq

Motion command sequencer in front of the heading PID controller. Accepts one heading or move command at a time from the command processor and drives the PID's `moving`, `dsrd_hdng` and `frwrd_spd` inputs. Ramps forward speed on heading-valid strobes and stops on wall-opening or obstruction events. Pulses `mv_cmplt` when each command finishes.

## Interface
- `SPD_INC`, 11'h018: forward speed step applied per `hdng_vld` during acceleration.
- `MAX_SPD`, 11'h2A0: forward speed ceiling.
- `TMO_CYC`, 24'hFF_FFFF: heading-settle timeout in clk cycles (used only with `NAV_TIMEOUT_EN`).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd` in 16: command word.
  - [15:13] opcode: 3'b001 heading, 3'b010 move.
  - [11:0] heading for the heading opcode.
  - [1] `stp_lft`, [0] `stp_rght` for the move opcode.
- `cmd_rdy` in 1: a command is pending.
- `clr_cmd_rdy` out 1: one-cycle acknowledge that `cmd` was consumed.
- `hdng_vld` in 1: new heading sample strobe (same strobe the PID uses).
- `at_hdng` in 1: PID heading error is within tolerance.
- `frwrd_opn` in 1: path ahead is clear.
- `lft_opn`, `rght_opn` in 1: side openings.
- `moving` out 1: enables the PID and its integrator.
- `dsrd_hdng` out 12, signed: desired heading.
- `frwrd_spd` out 11, unsigned: forward speed.
- `mv_cmplt` out 1: one-cycle pulse when a command completes.
- `tmo_err` out 1: sticky heading-timeout flag (tied 0 without the macro).

## Operation
- States:
  - IDLE: `moving`=0, `frwrd_spd`=0.
  - HDNG: `moving`=1, `frwrd_spd`=0.
  - RAMP_UP: `moving`=1.
  - RAMP_DN: `moving`=1.
- IDLE, `cmd_rdy`=1, heading opcode: latch `cmd[11:0]` into `dsrd_hdng`, pulse `clr_cmd_rdy`, go to HDNG.
- IDLE, `cmd_rdy`=1, move opcode: latch `stp_lft`/`stp_rght`, pulse `clr_cmd_rdy`, go to RAMP_UP. `dsrd_hdng` is unchanged.
- IDLE, any other opcode: pulse `clr_cmd_rdy` only. Command is discarded, no `mv_cmplt`.
- HDNG: when `at_hdng`=1 is sampled on a `hdng_vld` cycle, pulse `mv_cmplt` and go to IDLE.
- RAMP_UP, on each `hdng_vld`: `frwrd_spd` = min(`frwrd_spd`+`SPD_INC`, `MAX_SPD`).
- RAMP_UP stop events:
  - Normal stop: rising edge of `lft_opn` with `stp_lft`=1, or rising edge of `rght_opn` with `stp_rght`=1. Go to RAMP_DN, decel = 2×`SPD_INC`.
  - Emergency: `frwrd_opn`=0. Go to RAMP_DN, decel = 4×`SPD_INC`.
- Opening edges use a registered copy of `lft_opn`/`rght_opn` that is updated every cycle.
- If an emergency and a normal stop occur in the same cycle, the emergency decel is used.
- An emergency raised while already in RAMP_DN upgrades the decel to 4×.
- RAMP_DN, on each `hdng_vld`: `frwrd_spd` = max(`frwrd_spd`−decel, 0) with no underflow. When it reaches 0, pulse `mv_cmplt` and go to IDLE.
- `cmd_rdy` is ignored outside IDLE.
- Width rules:
  - Decel values are computed in 13 bits, then the result is clamped to 11 bits.
  - The `MAX_SPD` clamp is applied after the add.

## Timing
- All outputs are registered.
- Reset values: `moving`=0, `dsrd_hdng`=12'h000, `frwrd_spd`=0, `clr_cmd_rdy`=0, `mv_cmplt`=0, `tmo_err`=0, state IDLE.
- `clr_cmd_rdy` and the new `dsrd_hdng` appear 1 cycle after `cmd_rdy` is sampled in IDLE.
- `frwrd_spd` changes in the cycle after a `hdng_vld` sample, and only then.
- `mv_cmplt` is high for exactly 1 cycle, coincident with `moving` falling to 0.
- Reset asserted mid-move returns the block to IDLE and zeroes the speed immediately, with no `mv_cmplt`.

## Configuration
- `NAV_TIMEOUT_EN` defined:
  - A 24-bit counter clears on entry to HDNG and increments each cycle in HDNG.
  - Reaching `TMO_CYC` sets `tmo_err`, pulses `mv_cmplt` and returns to IDLE.
  - `tmo_err` clears on the next accepted command.
- `NAV_TIMEOUT_EN` undefined: no counter, `tmo_err` is constant 0, and HDNG waits indefinitely.

## Structure
- Shared package `nav_pkg` holds:
  - the state enum `nav_state_t`;
  - opcode localparams `OPC_HDNG`=3'b001 and `OPC_MOVE`=3'b010.
- One sub-module, `spd_ramp`: the saturating add/subtract speed register, enabled by `hdng_vld` and selected by up/down/decel.

## Test plan
- Reset, then a heading command 16'h23FF with `cmd_rdy` → `clr_cmd_rdy` pulse, `dsrd_hdng`=12'h3FF, `moving`=1, `frwrd_spd`=0. Assert `at_hdng` with `hdng_vld` → one `mv_cmplt` pulse, back to IDLE.
- Move command 16'h4002, then 40 `hdng_vld` strobes → `frwrd_spd` steps by 0x18 and holds at 0x2A0.
- Continue the previous case and raise `lft_opn` → speed falls by 0x30 per `hdng_vld` to 0, then `mv_cmplt`. A `rght_opn` edge in the same run has no effect.
- At speed, drop `frwrd_opn` in the same cycle as a `lft_opn` edge → decel 0x60 per strobe; the final step clamps to 0 with no wrap.
- Pulse `rst_n` low mid-ramp → all outputs return to reset values at once, no `mv_cmplt`.
- With `NAV_TIMEOUT_EN` and `TMO_CYC`=100, give a heading command with `at_hdng` held 0 → `tmo_err`=1 and `mv_cmplt` after 100 cycles; the next command clears `tmo_err`.
